i2c_bus_arbiter: RTL

//   Shares the single ADXL345 I2C bus (SCL, CS, open-drain SDA) between N frame engines
//   (single read, single write, burst read). Each engine requests the bus; the block grants it

---
 rtl/i2c_bus_arbiter_if.sv | 29 ++
 rtl/i2c_bus_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/i2c_bus_arbiter_if.sv
// Engine-side and bus-side signals of the shared ADXL345 I2C bus arbiter.
// The arbiter uses the slave view; the engines (or a bench) use the master view.
interface i2c_bus_arbiter_if #(
  parameter int unsigned N_REQ = 3
);
  logic [N_REQ-1:0] Req_i;
  logic [N_REQ-1:0] Done_i;
  logic [N_REQ-1:0] SCL_i;
  logic [N_REQ-1:0] CS_i;
  logic [N_REQ-1:0] SDA_Low_i;
  logic [N_REQ-1:0] Debug_i;
  logic [N_REQ-1:0] Grant_o;
  logic             SCL_o;
  logic             CS_o;
  logic             SDA_Low_o;
  logic             Debug_o;
  logic             Busy_o;
  logic             Timeout_o;

  modport slave (
    input  Req_i, Done_i, SCL_i, CS_i, SDA_Low_i, Debug_i,
    output Grant_o, SCL_o, CS_o, SDA_Low_o, Debug_o, Busy_o, Timeout_o
  );

  modport master (
    output Req_i, Done_i, SCL_i, CS_i, SDA_Low_i, Debug_i,
    input  Grant_o, SCL_o, CS_o, SDA_Low_o, Debug_o, Busy_o, Timeout_o
  );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// Round-robin owner of the single ADXL345 I2C bus. Holds a grant until the owner reports
// frame done (or drops its request), inserts a bus-free guard time between frames, and
// revokes grants held longer than TIMEOUT_CYCLES.
module i2c_bus_arbiter #(
  parameter int unsigned N_REQ          = 3,
  parameter int unsigned GUARD_CYCLES   = 250,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_W          = 20
) (
  input logic               Clk_i,
  input logic               Reset_i,
  i2c_bus_arbiter_if.slave  bus
);

  localparam int unsigned      PTR_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CNT_W-1:0] GUARD_LAST   = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StGrant, StGuard} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             timeout_q, timeout_d;

  logic [N_REQ-1:0] win_onehot;
  logic [PTR_W-1:0] win_next_ptr;
  logic             win_found;
  logic             owner_release;

  // Round-robin search: first requesting engine at or above the pointer, wrapping.
  always_comb begin
    int unsigned idx;
    idx          = 0;
    win_onehot   = '0;
    win_next_ptr = ptr_q;
    win_found    = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      for (int unsigned j = 0; j < N_REQ; j++) begin
        if (!win_found && (j == idx) && bus.Req_i[j]) begin
          win_found     = 1'b1;
          win_onehot[j] = 1'b1;
          win_next_ptr  = (j == N_REQ - 1) ? '0 : PTR_W'(j + 1);
        end
      end
    end
  end

  // Owner finished its frame, or abandoned it by dropping its request.
  assign owner_release = |(bus.Done_i & grant_q) || !(|(bus.Req_i & grant_q));

  // Next-state logic; done/abort is checked before timeout so done wins a tie.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    timeout_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (win_found) begin
          grant_d = win_onehot;
          ptr_d   = win_next_ptr;
          cnt_d   = '0;
          state_d = StGrant;
        end
      end
      StGrant: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (owner_release) begin
          grant_d = '0;
          cnt_d   = '0;
          state_d = StGuard;
        end else if (cnt_q == TIMEOUT_LAST) begin
          grant_d   = '0;
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = StGuard;
        end
      end
      StGuard: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == GUARD_LAST) begin
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: begin
        grant_d = '0;
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge Clk_i) begin
    if (!Reset_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      grant_q   <= '0;
      ptr_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      timeout_q <= timeout_d;
    end
  end

  // Bus mux driven from the registered grant; idle levels when nobody owns the bus.
  always_comb begin
    bus.SCL_o     = 1'b1;
    bus.CS_o      = 1'b1;
    bus.SDA_Low_o = 1'b0;
    bus.Debug_o   = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        bus.SCL_o     = bus.SCL_i[i];
        bus.CS_o      = bus.CS_i[i];
        bus.SDA_Low_o = bus.SDA_Low_i[i];
        bus.Debug_o   = bus.Debug_i[i];
      end
    end
  end

  assign bus.Grant_o   = grant_q;
  assign bus.Busy_o    = (state_q != StIdle);
  assign bus.Timeout_o = timeout_q;

endmodule
